md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_div_step.sv | 28 ++
 rtl/md_ctrl.sv | 154 +++++++++++++++
 tb/tb_md_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Desc     : Shared state encoding, divider constants and helpers for md_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    // Absolute value of an operand when it is to be treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_div_step.sv
// ============================================================================
// Module   : div_step
// Desc     : One restoring shift-subtract iteration of the unsigned divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step (
    input  logic [31:0] rem,
    input  logic        dbit,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic        qbit
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // rem < divisor always holds, so the shifted value fits in 33 bits and
    // bit 32 of the difference is a clean borrow flag.
    assign w_shift  = {rem, dbit};
    assign w_diff   = w_shift - {1'b0, divisor};
    assign qbit     = ~w_diff[32];
    assign next_rem = qbit ? w_diff[31:0] : w_shift[31:0];

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// ============================================================================
// Module   : md_ctrl
// Desc     : Multi-cycle MULT/DIV unit driving the HI/LO register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_div,
    input  logic        start_mult,
    input  logic        sign,
    input  logic        annul,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        stall,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic               r_sign;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_dvs;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_accept;
    logic               w_we;
    logic [63:0]        w_ext_a;
    logic [63:0]        w_ext_b;
    logic [63:0]        w_prod;
    logic [31:0]        w_next_rem;
    logic               w_qbit;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [31:0]        w_q_fix;
    logic [31:0]        w_r_fix;

    assign w_accept = (r_state == ST_IDLE) && !annul && (start_div || start_mult);

    assign stall  = resetn && (w_accept || (r_state == ST_MULT) ||
                               (r_state == ST_DIV) || (r_state == ST_FIX));
    assign busy   = resetn && (r_state != ST_IDLE);
    assign w_we   = resetn && (r_state == ST_DONE) && !annul;
    assign hi_we  = w_we;
    assign lo_we  = w_we;
    assign hi_out = resetn ? r_hi : 32'd0;
    assign lo_out = resetn ? r_lo : 32'd0;

    // Extending both operands to 64 bits makes one truncated multiply serve
    // both the signed and unsigned cases.
    assign w_ext_a = {{32{r_sign & r_opa[31]}}, r_opa};
    assign w_ext_b = {{32{r_sign & r_opb[31]}}, r_opb};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_neg_q = r_sign && (r_opa[31] ^ r_opb[31]);
    assign w_neg_r = r_sign && r_opa[31];
    assign w_q_fix = w_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_r_fix = w_neg_r ? (~r_rem + 32'd1) : r_rem;

    div_step u_div_step (
        .rem      (r_rem),
        .dbit     (r_quo[31]),
        .divisor  (r_dvs),
        .next_rem (w_next_rem),
        .qbit     (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_sign  <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opa   <= opa;
                        r_opb   <= opb;
                        r_sign  <= sign;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= magnitude(opa, sign);
                        r_dvs   <= magnitude(opb, sign);
                        r_state <= start_div ? ST_DIV : ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (annul) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (annul) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Dividend bits shift out of r_quo's top as quotient bits enter its bottom.
                        r_rem <= w_next_rem;
                        r_quo <= {r_quo[30:0], w_qbit};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (annul) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_opb == 32'd0) begin
                            r_hi <= r_opa;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// ============================================================================
// Module   : tb_md_ctrl
// Desc     : Self-checking bench for md_ctrl: transaction model plus directed pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        resetn, start_div, start_mult, sign, annul;
    logic [31:0] opa, opb;
    logic        stall, busy, hi_we, lo_we;
    logic [31:0] hi_out, lo_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int strobe_cnt  = 0;
    int stall_cnt   = 0;
    int last_strobe = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    // Transaction-level model: one operation in flight with a known finish cycle.
    bit          m_active = 1'b0;
    int          m_done   = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

    md_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_div  (start_div),
        .start_mult (start_mult),
        .sign       (sign),
        .annul      (annul),
        .opa        (opa),
        .opb        (opb),
        .stall      (stall),
        .busy       (busy),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void calc(input bit is_div, input bit sg, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] rh,
                                 output logic [31:0] rl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (!is_div) begin
            p  = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            p  = 64'(q);
            rl = p[31:0];
            p  = 64'(r);
            rh = p[31:0];
        end
    endfunction

    initial forever begin
        logic e_stall, e_busy, e_we;
        logic [31:0] e_hi, e_lo;
        @(negedge clk);
        if (!resetn) begin
            e_stall = 0; e_busy = 0; e_we = 0; e_hi = '0; e_lo = '0;
        end else if (!m_active) begin
            e_stall = !annul && (start_div || start_mult);
            e_busy = 0; e_we = 0; e_hi = m_hi; e_lo = m_lo;
        end else if (cyc == m_done) begin
            e_stall = 0; e_busy = 1; e_we = !annul; e_hi = m_rhi; e_lo = m_rlo;
        end else begin
            e_stall = 1; e_busy = 1; e_we = 0; e_hi = m_hi; e_lo = m_lo;
        end
        check("stall", 64'(stall), 64'(e_stall));
        check("busy", 64'(busy), 64'(e_busy));
        check("hi_we", 64'(hi_we), 64'(e_we));
        check("lo_we", 64'(lo_we), 64'(e_we));
        check("hi_out", 64'(hi_out), 64'(e_hi));
        check("lo_out", 64'(lo_out), 64'(e_lo));

        if (hi_we) begin
            strobe_cnt++;
            last_strobe = cyc;
            last_hi = hi_out;
            last_lo = lo_out;
        end
        if (stall) stall_cnt++;

        if (!resetn) begin
            m_active = 0; m_hi = '0; m_lo = '0;
        end else if (!m_active) begin
            if (!annul && (start_div || start_mult)) begin
                m_active = 1;
                m_done = cyc + (start_div ? 34 : 2);
                calc(start_div, sign, opa, opb, m_rhi, m_rlo);
            end
        end else if (cyc == m_done) begin
            m_active = 0; m_hi = m_rhi; m_lo = m_rlo;
        end else if (annul) begin
            m_active = 0;
        end
    end

    task automatic cyc_in(input bit sd, input bit sm, input bit sg, input bit an,
                          input logic [31:0] a, input logic [31:0] b, input bit rn);
        start_div = sd; start_mult = sm; sign = sg; annul = an;
        opa = a; opb = b; resetn = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc_in(0, 0, 0, 0, 32'd0, 32'd0, 1);
    endtask

    task automatic op_check(input string nm, input bit sd, input bit sm, input bit sg,
                            input logic [31:0] a, input logic [31:0] b, input int lat,
                            input logic [31:0] eh, input logic [31:0] el);
        int t0 = cyc;
        int n0 = strobe_cnt;
        int s0 = stall_cnt;
        cyc_in(sd, sm, sg, 0, a, b, 1);
        repeat (lat + 2) idle();
        check({nm, " strobes"}, 64'(strobe_cnt - n0), 64'd1);
        check({nm, " latency"}, 64'(last_strobe - t0), 64'(lat));
        check({nm, " stall cycles"}, 64'(stall_cnt - s0), 64'(lat));
        check({nm, " hi"}, 64'(last_hi), 64'(eh));
        check({nm, " lo"}, 64'(last_lo), 64'(el));
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0, n0, s0;
        resetn = 0; start_div = 0; start_mult = 0; sign = 0; annul = 0;
        opa = '0; opb = '0;
        repeat (3) cyc_in(0, 0, 0, 0, 32'd0, 32'd0, 0);
        idle();
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi_out", 64'(hi_out), 64'd0);
        check("reset lo_out", 64'(lo_out), 64'd0);

        op_check("smult", 0, 1, 1, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op_check("umult", 0, 1, 0, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
        op_check("sdiv -7/2", 1, 0, 1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_check("divu 100/0", 1, 0, 0, 32'd100, 32'd0, 34, 32'h0000_0064, 32'hFFFF_FFFF);

        // Annul in the middle of a divide.
        t0 = cyc; n0 = strobe_cnt; s0 = stall_cnt;
        cyc_in(1, 0, 0, 0, 32'd500, 32'd3, 1);
        repeat (9) idle();
        cyc_in(0, 0, 0, 1, 32'd0, 32'd0, 1);
        check("annul busy after", 64'(busy), 64'd0);
        repeat (30) idle();
        check("annul strobes", 64'(strobe_cnt - n0), 64'd0);
        check("annul stall cycles", 64'(stall_cnt - s0), 64'd11);

        // Both starts together, then a start_mult that must be ignored.
        t0 = cyc; n0 = strobe_cnt;
        cyc_in(1, 1, 0, 0, 32'd1000, 32'd7, 1);
        repeat (4) idle();
        cyc_in(0, 1, 1, 0, 32'd9, 32'd9, 1);
        repeat (36) idle();
        check("both strobes", 64'(strobe_cnt - n0), 64'd1);
        check("both latency", 64'(last_strobe - t0), 64'd34);
        check("both hi", 64'(last_hi), 64'd6);
        check("both lo", 64'(last_lo), 64'd142);

        // Reset at cycle 20 of a divide.
        n0 = strobe_cnt;
        cyc_in(1, 0, 1, 0, 32'hFFFF_FF00, 32'd5, 1);
        repeat (19) idle();
        cyc_in(0, 0, 0, 0, 32'd0, 32'd0, 0);
        idle();
        check("post-reset hi_out", 64'(hi_out), 64'd0);
        check("post-reset lo_out", 64'(lo_out), 64'd0);
        repeat (20) idle();
        check("reset strobes", 64'(strobe_cnt - n0), 64'd0);
        op_check("mult after reset", 0, 1, 0, 32'd3, 32'd5, 2, 32'd0, 32'd15);

        // Randomized traffic against the model.
        repeat (4000) begin
            cyc_in($urandom_range(11) == 0, $urandom_range(9) == 0, 1'($urandom),
                   $urandom_range(63) == 0, rnd_op(), rnd_op(), $urandom_range(399) != 0);
        end
        repeat (40) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
